// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the VRAM arbiter: FSM state encoding and RAM geometry defaults.
package vram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        V1,
        V2,
        V3,
        C1,
        C2
    } state_e;

    localparam int COLOR_OFS_DEF = 1024;
    localparam int DATA_W        = 8;

endpackage

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between the Z80 and the video char/colour fetch.
// Optional macro VRAM_ARB_FAIR_EN: CPU goes first after a video grant when both are pending.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int COLOR_OFS = COLOR_OFS_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [9:0]        vid_addr,
    output logic [DATA_W-1:0] vid_char,
    output logic [DATA_W-1:0] vid_color,
    output logic              vid_valid,
    output logic              vid_ovr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_e              state_q;
    logic                vid_pend_q;
    logic [9:0]          vid_addr_q;
    logic                vid_ovr_q;
    logic [DATA_W-1:0]   vid_char_q;
    logic [DATA_W-1:0]   vid_color_q;
    logic                vid_valid_q;
    logic [DATA_W-1:0]   cpu_dout_q;
    logic                cpu_ack_q;
    logic                cpu_wr_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic                ram_we_q;
    logic [DATA_W-1:0]   ram_din_q;

    logic                serve_cpu_first;
    logic                grant_vid;
    logic                grant_cpu;

`ifdef VRAM_ARB_FAIR_EN
    logic                last_vid_q;
    assign serve_cpu_first = last_vid_q & cpu_req;
`else
    assign serve_cpu_first = 1'b0;
`endif

    assign grant_vid = (state_q == IDLE) && vid_pend_q && !serve_cpu_first;
    assign grant_cpu = (state_q == IDLE) && !grant_vid && cpu_req;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            vid_pend_q  <= 1'b0;
            vid_addr_q  <= '0;
            vid_ovr_q   <= 1'b0;
            vid_char_q  <= '0;
            vid_color_q <= '0;
            vid_valid_q <= 1'b0;
            cpu_dout_q  <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_din_q   <= '0;
`ifdef VRAM_ARB_FAIR_EN
            last_vid_q  <= 1'b0;
`endif
        end else begin
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;

            // A request landing on the accept cycle is a fresh request, not an overrun.
            if (vid_req) begin
                vid_pend_q <= 1'b1;
                vid_addr_q <= vid_addr;
                if (vid_pend_q && !grant_vid) begin
                    vid_ovr_q <= 1'b1;
                end
            end else if (grant_vid) begin
                vid_pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (grant_vid) begin
                        ram_addr_q <= ADDR_W'(vid_addr_q);
                        ram_we_q   <= 1'b0;
                        state_q    <= V1;
`ifdef VRAM_ARB_FAIR_EN
                        last_vid_q <= 1'b1;
`endif
                    end else if (grant_cpu) begin
                        ram_addr_q <= cpu_addr;
                        ram_we_q   <= cpu_we;
                        ram_din_q  <= cpu_din;
                        cpu_wr_q   <= cpu_we;
                        state_q    <= C1;
`ifdef VRAM_ARB_FAIR_EN
                        last_vid_q <= 1'b0;
`endif
                    end
                end
                V1: begin
                    // Colour byte sits at a fixed offset from the char byte, wrapping in the RAM.
                    ram_addr_q <= ram_addr_q + ADDR_W'(COLOR_OFS);
                    state_q    <= V2;
                end
                V2: begin
                    vid_char_q <= ram_dout;
                    state_q    <= V3;
                end
                V3: begin
                    vid_color_q <= ram_dout;
                    vid_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                C1: begin
                    ram_we_q <= 1'b0;
                    state_q  <= C2;
                end
                C2: begin
                    if (!cpu_wr_q) begin
                        cpu_dout_q <= ram_dout;
                    end
                    cpu_ack_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vid_char  = vid_char_q;
    assign vid_color = vid_color_q;
    assign vid_valid = vid_valid_q;
    assign vid_ovr   = vid_ovr_q;
    assign cpu_dout  = cpu_dout_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_wait  = cpu_req & ~cpu_ack_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: transaction-level timing model checked every cycle, directed cases, random traffic.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int ADDR_W = 11;
    localparam int OFS    = 1024;
    localparam int OFS2   = 'h500;
`ifdef VRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [9:0]  vid_addr;
    logic        cpu_req, cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  vid_char, vid_color, cpu_dout, ram_din, ram_dout;
    logic        vid_valid, vid_ovr, cpu_ack, cpu_wait, ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  vid_char2, vid_color2, cpu_dout2, ram_din2, ram_dout2;
    logic        vid_valid2, vid_ovr2, cpu_ack2, cpu_wait2, ram_we2;
    logic [10:0] ram_addr2;

    always #5 clk_sys = ~clk_sys;

    vram_arbiter #(.ADDR_W(ADDR_W), .COLOR_OFS(OFS)) u_dut (
        .clk_sys(clk_sys), .reset(reset), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_char(vid_char), .vid_color(vid_color), .vid_valid(vid_valid), .vid_ovr(vid_ovr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Second instance only exercises the colour-offset wrap; its RAM writes mirror the first one's.
    vram_arbiter #(.ADDR_W(ADDR_W), .COLOR_OFS(OFS2)) u_dut2 (
        .clk_sys(clk_sys), .reset(reset), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_char(vid_char2), .vid_color(vid_color2), .vid_valid(vid_valid2), .vid_ovr(vid_ovr2),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout2), .cpu_ack(cpu_ack2), .cpu_wait(cpu_wait2),
        .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_din(ram_din2), .ram_dout(ram_dout2)
    );

    logic [7:0] ram [0:2047];
    always @(posedge clk_sys) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout  <= ram[ram_addr];
        ram_dout2 <= ram[ram_addr2];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the RAM and when each result is due, in absolute cycle numbers.
    logic [7:0]  mmem [0:2047];
    longint      cyc = 0;
    longint      free_at = 0, valid_at = -1, ack_at = -1, we_at = -1, col_at = -1;
    logic        m_vpend, m_ovr, m_last_vid, gv, gc, p_rd;
    logic [9:0]  m_vaddr;
    logic [7:0]  e_char, e_color, e_dout, e_din, p_char, p_color, p_dout;
    logic [10:0] e_addr, p_col_addr;
    logic        e_valid, e_ack, e_we;
    int          n_we = 0;
    longint      valid_q[$];
    longint      ack_q[$];

    initial begin
        forever begin
            @(posedge clk_sys);
            cyc++;
            if (reset) begin
                m_vpend = 0; m_ovr = 0; m_last_vid = 0; m_vaddr = '0;
                e_char = '0; e_color = '0; e_dout = '0; e_din = '0; e_addr = '0;
                e_valid = 0; e_ack = 0; e_we = 0;
                free_at = cyc + 1; valid_at = -1; ack_at = -1; we_at = -1; col_at = -1;
            end else begin
                gv = 0; gc = 0;
                if (cyc >= free_at) begin
                    if (m_vpend && !(FAIR && m_last_vid && cpu_req)) gv = 1;
                    else if (cpu_req) gc = 1;
                end
                if (gv) begin
                    e_addr     = 11'(m_vaddr);
                    p_col_addr = 11'((int'(m_vaddr) + OFS) & 2047);
                    p_char     = mmem[e_addr];
                    p_color    = mmem[p_col_addr];
                    col_at = cyc + 1; valid_at = cyc + 3; free_at = cyc + 4;
                    m_last_vid = 1;
                end else if (gc) begin
                    e_addr = cpu_addr;
                    e_din  = cpu_din;
                    p_rd   = !cpu_we;
                    p_dout = mmem[cpu_addr];
                    if (cpu_we) begin
                        mmem[cpu_addr] = cpu_din;
                        we_at = cyc;
                    end
                    ack_at = cyc + 2; free_at = cyc + 3;
                    m_last_vid = 0;
                end
                if (cyc == col_at) e_addr = p_col_addr;
                e_we    = (cyc == we_at);
                e_valid = (cyc == valid_at);
                if (e_valid) begin
                    e_char  = p_char;
                    e_color = p_color;
                end
                e_ack = (cyc == ack_at);
                if (e_ack && p_rd) e_dout = p_dout;
                if (vid_req) begin
                    if (m_vpend && !gv) m_ovr = 1;
                    m_vpend = 1;
                    m_vaddr = vid_addr;
                end else if (gv) begin
                    m_vpend = 0;
                end
            end
            #1;
            chk("vid_valid", 32'(vid_valid), 32'(e_valid));
            chk("cpu_ack",   32'(cpu_ack),   32'(e_ack));
            chk("ram_we",    32'(ram_we),    32'(e_we));
            chk("ram_addr",  32'(ram_addr),  32'(e_addr));
            chk("ram_din",   32'(ram_din),   32'(e_din));
            chk("vid_ovr",   32'(vid_ovr),   32'(m_ovr));
            chk("cpu_dout",  32'(cpu_dout),  32'(e_dout));
            chk("cpu_wait",  32'(cpu_wait),  32'(cpu_req & ~e_ack));
            if (e_valid || reset) begin
                chk("vid_char",  32'(vid_char),  32'(e_char));
                chk("vid_color", 32'(vid_color), 32'(e_color));
            end
            if (vid_valid === 1'b1) valid_q.push_back(cyc);
            if (cpu_ack === 1'b1)   ack_q.push_back(cyc);
            if (ram_we === 1'b1)    n_we++;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic wait_valid_count(input int target, input int budget);
        for (int k = 0; k < budget && valid_q.size() < target; k++) tick();
    endtask

    task automatic cpu_access(input logic we, input logic [10:0] addr, input logic [7:0] din,
                              output logic [7:0] dout, output int lat, output int wait_ok);
        @(negedge clk_sys);
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        lat = 0; dout = '0; wait_ok = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            lat++;
            if (cpu_ack) begin
                dout = cpu_dout;
                break;
            end
            if (!cpu_wait) wait_ok = 0;
        end
        @(negedge clk_sys);
        cpu_req = 0;
    endtask

    logic [7:0] d;
    int         lat, wok, nv0, na0, nw0, got;

    initial begin
        reset = 1; vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
        for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
        ram[11'h005] = 8'h41; ram[11'h405] = 8'h71;
        ram[11'h3FF] = 8'hE7; ram[11'h7FF] = 8'h9C; ram[11'h0FF] = 8'h3E;
        ram[11'h010] = 8'h11; ram[11'h410] = 8'h22;
        ram[11'h020] = 8'hC3; ram[11'h420] = 8'h5C;
        for (int i = 0; i < 2048; i++) mmem[i] = ram[i];
        repeat (3) @(negedge clk_sys);
        chk("reset_ram_we", 32'(ram_we), 32'h0);
        chk("reset_vid_ovr", 32'(vid_ovr), 32'h0);
        reset = 0;

        // Single fetch from an idle arbiter: valid occupies the 5th period after the request edge.
        nv0 = valid_q.size();
        @(negedge clk_sys); vid_req = 1; vid_addr = 10'h005;
        tick(); lat = int'(cyc);
        @(negedge clk_sys); vid_req = 0;
        wait_valid_count(nv0 + 1, 12);
        chk("t1_valid_seen", 32'(valid_q.size() - nv0), 32'd1);
        if (valid_q.size() > nv0) chk("t1_latency", 32'(valid_q[nv0] - lat), 32'd4);
        chk("t1_char", 32'(vid_char), 32'h41);
        chk("t1_color", 32'(vid_color), 32'h71);
        chk("t1_ovr", 32'(vid_ovr), 32'h0);

        // CPU write then read back.
        nw0 = n_we;
        cpu_access(1'b1, 11'h123, 8'h5A, d, lat, wok);
        chk("t2_wr_latency", 32'(lat), 32'd3);
        chk("t2_wr_wait", 32'(wok), 32'd1);
        chk("t2_wr_we_cycles", 32'(n_we - nw0), 32'd1);
        nw0 = n_we;
        cpu_access(1'b0, 11'h123, 8'h00, d, lat, wok);
        chk("t2_rd_latency", 32'(lat), 32'd3);
        chk("t2_rd_data", 32'(d), 32'h5A);
        chk("t2_rd_we_cycles", 32'(n_we - nw0), 32'd0);

        // Both pending at one IDLE decision: video first, CPU 3 cycles after the valid.
        nv0 = valid_q.size(); na0 = ack_q.size();
        @(negedge clk_sys); vid_req = 1; vid_addr = 10'h005;
        @(negedge clk_sys); vid_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 11'h405;
        got = 0;
        for (int k = 0; k < 30 && !got; k++) begin tick(); if (cpu_ack) got = 1; end
        @(negedge clk_sys); cpu_req = 0;
        chk("t3a_ack_seen", 32'(ack_q.size() - na0), 32'd1);
        chk("t3a_dout", 32'(cpu_dout), 32'h71);
        if (ack_q.size() > na0 && valid_q.size() > nv0)
            chk("t3a_ack_after_valid", 32'(ack_q[na0] - valid_q[nv0]), 32'd3);

        // Second video request queued behind the first: fairness decides who goes next.
        nv0 = valid_q.size(); na0 = ack_q.size();
        @(negedge clk_sys); vid_req = 1; vid_addr = 10'h010;
        @(negedge clk_sys); vid_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 11'h005;
        @(negedge clk_sys); vid_req = 1; vid_addr = 10'h020;
        @(negedge clk_sys); vid_req = 0;
        got = 0;
        for (int k = 0; k < 30 && !got; k++) begin tick(); if (cpu_ack) got = 1; end
        @(negedge clk_sys); cpu_req = 0;
        wait_valid_count(nv0 + 2, 20);
        chk("t3b_valids", 32'(valid_q.size() - nv0), 32'd2);
        chk("t3b_dout", 32'(cpu_dout), 32'h41);
        if (ack_q.size() > na0 && valid_q.size() > nv0 + 1) begin
`ifdef VRAM_ARB_FAIR_EN
            chk("t3b_cpu_before_2nd", 32'(valid_q[nv0 + 1] - ack_q[na0]), 32'd4);
`else
            chk("t3b_2nd_before_cpu", 32'(ack_q[na0] - valid_q[nv0 + 1]), 32'd3);
`endif
        end

        // Overrun while the CPU holds the RAM: only the later address is fetched.
        nv0 = valid_q.size();
        fork
            cpu_access(1'b1, 11'h300, 8'hAB, d, lat, wok);
            begin
                @(negedge clk_sys); vid_req = 1; vid_addr = 10'h010;
                @(negedge clk_sys); vid_req = 0;
                @(negedge clk_sys); vid_req = 1; vid_addr = 10'h020;
                @(negedge clk_sys); vid_req = 0;
            end
        join
        wait_valid_count(nv0 + 1, 12);
        chk("t4_char", 32'(vid_char), 32'hC3);
        chk("t4_color", 32'(vid_color), 32'h5C);
        repeat (8) tick();
        chk("t4_one_fetch", 32'(valid_q.size() - nv0), 32'd1);
        chk("t4_ovr", 32'(vid_ovr), 32'h1);

        // Colour address wrap, with both offsets; overrun flag must still be held.
        nv0 = valid_q.size();
        @(negedge clk_sys); vid_req = 1; vid_addr = 10'h3FF;
        @(negedge clk_sys); vid_req = 0;
        wait_valid_count(nv0 + 1, 12);
        chk("t5_char", 32'(vid_char), 32'hE7);
        chk("t5_color", 32'(vid_color), 32'h9C);
        chk("t5_char_ofs500", 32'(vid_char2), 32'hE7);
        chk("t5_color_ofs500", 32'(vid_color2), 32'h3E);
        chk("t5_ovr_sticky", 32'(vid_ovr), 32'h1);

        // Reset during V2 of a fetch.
        nv0 = valid_q.size();
        @(negedge clk_sys); vid_req = 1; vid_addr = 10'h005;
        @(negedge clk_sys); vid_req = 0;
        @(negedge clk_sys);
        @(negedge clk_sys); reset = 1;
        tick();
        chk("t6a_ovr_clr", 32'(vid_ovr), 32'h0);
        chk("t6a_char_clr", 32'(vid_char), 32'h0);
        chk("t6a_ram_addr_clr", 32'(ram_addr), 32'h0);
        @(negedge clk_sys); reset = 0;
        repeat (8) tick();
        chk("t6a_no_valid", 32'(valid_q.size() - nv0), 32'd0);

        // Reset during C1 of a write.
        na0 = ack_q.size();
        @(negedge clk_sys); cpu_req = 1; cpu_we = 1; cpu_addr = 11'h055; cpu_din = 8'h77;
        tick();
        chk("t6b_we_before", 32'(ram_we), 32'h1);
        @(negedge clk_sys); reset = 1;
        tick();
        chk("t6b_we_dropped", 32'(ram_we), 32'h0);
        chk("t6b_dout_clr", 32'(cpu_dout), 32'h0);
        @(negedge clk_sys); reset = 0; cpu_req = 0;
        repeat (6) tick();
        chk("t6b_no_ack", 32'(ack_q.size() - na0), 32'd0);

        // Random traffic with occasional resets; the per-cycle model does the checking.
        for (int k = 0; k < 800; k++) begin
            @(negedge clk_sys);
            reset    = ($urandom_range(0, 299) == 0);
            vid_req  = ($urandom_range(0, 9) == 0);
            vid_addr = 10'($urandom);
            if (reset) begin
                cpu_req = 0;
            end else if (cpu_req) begin
                if (cpu_ack) cpu_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                cpu_req  = 1;
                cpu_we   = 1'($urandom_range(0, 1));
                cpu_addr = 11'($urandom);
                cpu_din  = 8'($urandom);
            end
        end
        @(negedge clk_sys);
        reset = 0; vid_req = 0; cpu_req = 0;
        repeat (10) @(negedge clk_sys);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
